// File: rtl/mul_ctrl_pkg.sv
// Shared definitions for the shift-add multiplier sequencer.
package mul_ctrl_pkg;

  // Sequencer states, 3-bit binary encoding.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ACC  = 3'd2,
    SHR  = 3'd3,
    SHL  = 3'd4,
    DONE = 3'd5
  } state_e;

  // Default operand width and the matching bit-step counter width.
  localparam int N_DEF = 8;
  localparam int CNT_W = $clog2(N_DEF + 1);

  // Counter width needed to hold 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/shift_add_mul_ctrl.sv
// Sequencing FSM for the shift-add multiplier datapath.
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  IDLE  | waiting for start, all strobes low
//  LOAD  | load operands, clear accumulator, restart bit counter
//  ACC   | accumulate partial product (datapath gates with mplr LSB)
//  SHR   | shift multiplier right one bit
//  SHL   | shift multiplicand left one bit, count the bit-step
//  DONE  | one-cycle done pulse, product valid; always returns to IDLE
module shift_add_mul_ctrl
  import mul_ctrl_pkg::*;
#(
  parameter int N          = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     mplr_zero,
  output logic                     load,
  output logic                     acc_clr,
  output logic                     acc_en,
  output logic                     shft_right,
  output logic                     shft_left,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(N+1)-1:0]   bit_cnt
);

  localparam int             BC_W = cnt_width(N);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(N - 1);

  state_e            state_q, state_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic              run_st;

  // State and bit counter registers; reset abandons any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // Next-state, counter update and Moore output decode from state_q.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    load       = 1'b0;
    acc_clr    = 1'b0;
    acc_en     = 1'b0;
    shft_right = 1'b0;
    shft_left  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    run_st     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        load      = 1'b1;
        acc_clr   = 1'b1;
        busy      = 1'b1;
        run_st    = 1'b1;
        bit_cnt_d = '0;
        state_d   = ACC;
      end
      ACC: begin
        acc_en = 1'b1;
        busy   = 1'b1;
        run_st = 1'b1;
        // mplr_zero only matters here; with no early exit every bit is walked.
        if (EARLY_EXIT && mplr_zero) state_d = DONE;
        else                         state_d = SHR;
      end
      SHR: begin
        shft_right = 1'b1;
        busy       = 1'b1;
        run_st     = 1'b1;
        state_d    = SHL;
      end
      SHL: begin
        shft_left = 1'b1;
        busy      = 1'b1;
        run_st    = 1'b1;
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == LAST_BIT) state_d = DONE;
        else                       state_d = ACC;
      end
      DONE: begin
        // bit_cnt holds so the host can read how many steps were taken.
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
      end
    endcase

    // abort overrides any transition while an operation is running.
    if (abort && run_st) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
    end
  end

  assign bit_cnt = bit_cnt_q;

endmodule

// File: tb/tb_shift_add_mul_ctrl.sv
// Directed bench: two sequencers (early exit on/off) each driving a small
// behavioural datapath, checked against hand-computed latencies and products.
module tb_shift_add_mul_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] a_in = 8'd0;
  logic [7:0] b_in = 8'd0;

  logic load_e, acc_clr_e, acc_en_e, shr_e, shl_e, busy_e, done_e;
  logic load_n, acc_clr_n, acc_en_n, shr_n, shl_n, busy_n, done_n;
  logic [3:0] bc_e, bc_n;
  logic mz_e, mz_n;

  logic [7:0]  r_e = 8'd0, r_n = 8'd0;
  logic [15:0] l_e = 16'd0, l_n = 16'd0;
  logic [15:0] acc_e = 16'd0, acc_n = 16'd0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  shift_add_mul_ctrl #(.N(8), .EARLY_EXIT(1'b1)) dut_e (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mplr_zero(mz_e),
    .load(load_e), .acc_clr(acc_clr_e), .acc_en(acc_en_e), .shft_right(shr_e),
    .shft_left(shl_e), .busy(busy_e), .done(done_e), .bit_cnt(bc_e));

  shift_add_mul_ctrl #(.N(8), .EARLY_EXIT(1'b0)) dut_n (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mplr_zero(mz_n),
    .load(load_n), .acc_clr(acc_clr_n), .acc_en(acc_en_n), .shft_right(shr_n),
    .shft_left(shl_n), .busy(busy_n), .done(done_n), .bit_cnt(bc_n));

  assign mz_e = (r_e == 8'd0);
  assign mz_n = (r_n == 8'd0);

  // Behavioural datapath for the early-exit instance.
  always @(posedge clk) begin
    if (load_e) begin
      r_e <= a_in;
      l_e <= {8'd0, b_in};
    end else if (shr_e) r_e <= r_e >> 1;
    else if (shl_e) l_e <= l_e << 1;
    if (acc_clr_e) acc_e <= 16'd0;
    else if (acc_en_e && r_e[0]) acc_e <= acc_e + l_e;
  end

  // Behavioural datapath for the fixed-length instance.
  always @(posedge clk) begin
    if (load_n) begin
      r_n <= a_in;
      l_n <= {8'd0, b_in};
    end else if (shr_n) r_n <= r_n >> 1;
    else if (shl_n) l_n <= l_n << 1;
    if (acc_clr_n) acc_n <= 16'd0;
    else if (acc_en_n && r_n[0]) acc_n <= acc_n + l_n;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch one multiply on both instances and check latency, count, product.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input int lat_e_exp, input int bc_e_exp, input logic [15:0] prod);
    int lat_e, lat_n, bce, bcn, n_acc, n_shr, n_shl, n_bad;
    lat_e = -1; lat_n = -1; bce = 0; bcn = 0;
    n_acc = 0; n_shr = 0; n_shl = 0; n_bad = 0;
    a_in = a; b_in = b; start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done_e && lat_e < 0) begin lat_e = c; bce = int'(bc_e); end
      if (done_n && lat_n < 0) begin lat_n = c; bcn = int'(bc_n); end
      if (lat_n < 0) begin
        n_acc += int'(acc_en_n); n_shr += int'(shr_n); n_shl += int'(shl_n);
      end
      if ((int'(load_e) + int'(acc_en_e) + int'(shr_e) + int'(shl_e)) > 1) n_bad++;
      if ((int'(load_n) + int'(acc_en_n) + int'(shr_n) + int'(shl_n)) > 1) n_bad++;
      if (acc_clr_e != load_e || acc_clr_n != load_n) n_bad++;
      if (lat_e > 0 && lat_n > 0) break;
    end
    check_val({tag, " lat_e"}, lat_e, lat_e_exp);
    check_val({tag, " lat_n"}, lat_n, 26);
    check_val({tag, " bc_e"}, bce, bc_e_exp);
    check_val({tag, " bc_n"}, bcn, 8);
    check_val({tag, " prod_e"}, acc_e, prod);
    check_val({tag, " prod_n"}, acc_n, prod);
    check_val({tag, " triplets"}, {n_acc[7:0], n_shr[7:0], n_shl[7:0]}, 32'h00080808);
    check_val({tag, " strobes"}, n_bad, 0);
    repeat (2) @(negedge clk);
  endtask

  // Let both instances run out and count any done pulses.
  task automatic watch_no_done(input string tag, input int cycles);
    int n_done;
    n_done = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      n_done += int'(done_e) + int'(done_n);
    end
    check_val({tag, " no_done"}, n_done, 0);
  endtask

  initial begin
    int ld_e[$];
    int ld_n[$];

    // Reset state.
    #2 rst_n = 1'b0;
    #1;
    check_val("rst outs_e", {load_e, acc_clr_e, acc_en_e, shr_e, shl_e, busy_e, done_e, bc_e}, 0);
    check_val("rst outs_n", {load_n, acc_clr_n, acc_en_n, shr_n, shl_n, busy_n, done_n, bc_n}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Full-length run with large multiplier.
    run_op("ff03", 8'hFF, 8'h03, 26, 8, 16'h02FD);
    // Early exit after bit 2 consumed the last one.
    run_op("0507", 8'h05, 8'h07, 12, 3, 16'd35);
    // Zero multiplier exits in the first ACC.
    run_op("0055", 8'h00, 8'h55, 3, 0, 16'd0);

    // Reset asserted during ACC of bit 3.
    a_in = 8'hFF; b_in = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check_val("pre_rst acc_bc", {acc_en_e, bc_e}, {1'b1, 4'd3});
    rst_n = 1'b0;
    #1;
    check_val("midrst outs_e", {load_e, acc_clr_e, acc_en_e, shr_e, shl_e, busy_e, done_e, bc_e}, 0);
    check_val("midrst outs_n", {load_n, acc_clr_n, acc_en_n, shr_n, shl_n, busy_n, done_n, bc_n}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    watch_no_done("midrst", 30);
    check_val("midrst idle", {busy_e, busy_n}, 0);

    // Abort in SHR of bit 2.
    a_in = 8'hFF; b_in = 8'h02; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check_val("pre_abort shr_bc", {shr_e, bc_e, shr_n, bc_n}, {1'b1, 4'd2, 1'b1, 4'd2});
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_val("abort e", {busy_e, done_e, bc_e}, 0);
    check_val("abort n", {busy_n, done_n, bc_n}, 0);
    watch_no_done("abort", 30);
    run_op("0304", 8'h03, 8'h04, 9, 2, 16'd12);

    // abort together with start in IDLE does not block the load.
    a_in = 8'h00; b_in = 8'h00; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check_val("idle_abort load", {load_e, load_n}, 2'b11);
    repeat (30) @(negedge clk);

    // start held high: back-to-back runs, one IDLE cycle between them.
    a_in = 8'h05; b_in = 8'h07; start = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (load_e) ld_e.push_back(c);
      if (load_n) ld_n.push_back(c);
    end
    start = 1'b0;
    check_val("b2b n_loads_e", ld_e.size(), 5);
    check_val("b2b n_loads_n", ld_n.size(), 3);
    if (ld_e.size() >= 3) begin
      check_val("b2b ld_e1", ld_e[1], 14);
      check_val("b2b ld_e2", ld_e[2], 27);
    end
    if (ld_n.size() >= 2) check_val("b2b ld_n1", ld_n[1], 28);
    repeat (40) @(negedge clk);
    check_val("b2b final idle", {busy_e, busy_n}, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
